// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller.
// A single full_adder cell is reused for every bit, LSB first, and the
// carry is kept in a flip-flop between cycles. Operands arrive through a
// valid/ready handshake. The result comes back through a second valid/ready
// handshake with the carry-out and the signed overflow flag.

// full_adder: the team's one-bit full adder cell, built from gates.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x  = a ^ b;
  assign ab_a  = a & b;
  assign cx_a  = c & ab_x;
  assign sum   = ab_x ^ c;
  assign carry = ab_a | cx_a;
endmodule

module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic [W-1:0]  res_nxt;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_sum;
  logic          fa_carry;

  // The one shared adder cell always looks at the low bits of the shifters.
  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // The new result bit enters from the MSB side, so after W shifts bit 0 is in place.
  always_comb begin
    res_nxt        = res >> 1;
    res_nxt[W-1]   = fa_sum;
  end

  // Controller FSM. Every output is a register, so in_ready never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= fa_carry;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry holds the carry into the MSB here, so overflow is that XOR the carry out.
            sum       <= res_nxt;
            cout      <= fa_carry;
            ovf       <= carry ^ fa_carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl, W=8.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checkCount = 0;
  int failCount  = 0;

  serial_add_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Independent arithmetic model: {ovf, cout, sum}.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input logic ci, input logic sb);
    logic [W-1:0] bo;
    logic [W:0]   full;
    logic         ov;
    bo   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bo} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    ov   = (av[W-1] == bo[W-1]) && (full[W-1] != av[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Step one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, wait for the result, check it, and optionally backpressure.
  task automatic applyStimulus(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic ci, input logic sb,
                               input logic [W-1:0] expSum, input logic expCout, input logic expOvf,
                               input int holdCycles);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = ci;
    sub = sb;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(W));
    checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum));
    checkOutput({tag, "_cout"}, 64'(cout), 64'(expCout));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(1));
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = i[0];
      a = av ^ 8'hA5;
      b = bv ^ 8'h3C;
      tick();
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      checkOutput({tag, "_hold_sum"}, 64'(sum), 64'(expSum));
      checkOutput({tag, "_hold_cout"}, 64'(cout), 64'(expCout));
      checkOutput({tag, "_hold_ovf"}, 64'(ovf), 64'(expOvf));
      checkOutput({tag, "_hold_inready"}, 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_drained"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
    checkOutput({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  logic [W-1:0] ra [4];
  logic [W-1:0] rb [4];
  logic         rc [4];
  logic         rs [4];
  int           acceptCycle [4];

  // Main directed sequence.
  initial begin
    int cyc;
    int idx;
    int ridx;
    logic [W+1:0] exp;
    logic acc;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    #12;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_sum", 64'(sum), 64'(0));
    checkOutput("rst_cout", 64'(cout), 64'(0));
    checkOutput("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    applyStimulus("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    applyStimulus("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    applyStimulus("addcin", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0);
    applyStimulus("sub1020", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    applyStimulus("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    applyStimulus("bp", 8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 5);
    applyStimulus("afterbp", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);

    // Abort an operation after three RUN cycles with an off-edge reset.
    in_valid = 1'b1;
    a = 8'hC3;
    b = 8'h5E;
    cin = 1'b1;
    sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'(1));
    checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_sum", 64'(sum), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus("postabort", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    // Back-to-back: in_valid and out_ready held high for four random operations.
    for (int i = 0; i < 4; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
      acceptCycle[i] = 0;
    end
    idx = 0;
    ridx = 0;
    cyc = 0;
    a = ra[0];
    b = rb[0];
    cin = rc[0];
    sub = rs[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (ridx < 4 && cyc < 200) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        exp = refModel(ra[ridx], rb[ridx], rc[ridx], rs[ridx]);
        checkOutput($sformatf("b2b%0d_sum", ridx), 64'(sum), 64'(exp[W-1:0]));
        checkOutput($sformatf("b2b%0d_cout", ridx), 64'(cout), 64'(exp[W]));
        checkOutput($sformatf("b2b%0d_ovf", ridx), 64'(ovf), 64'(exp[W+1]));
        ridx++;
      end
      tick();
      cyc++;
      if (acc) begin
        acceptCycle[idx] = cyc;
        idx++;
        if (idx < 4) begin
          a = ra[idx];
          b = rb[idx];
          cin = rc[idx];
          sub = rs[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checkOutput("b2b_results", 64'(ridx), 64'(4));
    checkOutput("b2b_accepts", 64'(idx), 64'(4));
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("b2b_spacing%0d", i), 64'(acceptCycle[i] - acceptCycle[i-1]), 64'(W + 2));
    end
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
